// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the data-memory stage.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  // Byte-enable mask: size bytes starting at ofs, clipped to nb lanes.
  function automatic logic [7:0] be_mask(input logic [1:0] size,
                                         input logic [2:0] ofs,
                                         input int unsigned nb);
    logic [15:0] m;
    logic [7:0]  lanes;
    case (size)
      SZ_BYTE: m = 16'h0001;
      SZ_HALF: m = 16'h0003;
      SZ_WORD: m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m     = m << ofs;
    lanes = (nb >= 8) ? 8'hFF : 8'((32'd1 << nb) - 32'd1);
    return m[7:0] & lanes;
  endfunction

  // Shift the addressed lanes down to the LSBs and sign/zero extend.
  function automatic logic [63:0] extend(input logic [63:0] word,
                                         input logic [1:0]  size,
                                         input logic [2:0]  ofs,
                                         input logic        is_unsigned);
    logic [63:0] s;
    s = word >> {ofs, 3'b000};
    case (size)
      SZ_BYTE: return {{56{~is_unsigned & s[7]}}, s[7:0]};
      SZ_HALF: return {{48{~is_unsigned & s[15]}}, s[15:0]};
      SZ_WORD: return {{32{~is_unsigned & s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  // Alignment / legality of a CPU access for the given data width.
  function automatic logic access_legal(input logic [1:0]  size,
                                        input logic [2:0]  ofs,
                                        input int unsigned data_w);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return (ofs[0] == 1'b0);
      SZ_WORD: return (ofs[1:0] == 2'b00);
      default: return (data_w == 64) && (ofs == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/memory_access_dp_ram.sv
// True dual-port RAM, per-byte write enables, registered read, no array reset.
module dp_ram_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic [DATA_W/8-1:0]   we_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     wdata_a,
  output logic [DATA_W-1:0]     rdata_a,
  input  logic [DATA_W/8-1:0]   we_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     wdata_b,
  output logic [DATA_W-1:0]     rdata_b
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first on both ports; arbitration keeps the ports on different words when writing.
  always_ff @(posedge clk) begin
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
    for (int unsigned i = 0; i < NB; i++) begin
      if (we_a[i]) mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
      if (we_b[i]) mem[addr_b][i*8 +: 8] <= wdata_b[i*8 +: 8];
    end
  end

endmodule

// File: rtl/memory_access_dp.sv
// Data-memory stage: CPU byte/half/word/dword port A, host word port B with CPU-priority arbitration.
module memory_access_dp
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_Mem_wr_en,
  input  logic              i_Mem_rd_en,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  input  logic [DATA_W-1:0] i_ALU_res,
  input  logic [DATA_W-1:0] i_ST_value,
  output logic [DATA_W-1:0] o_datamem_out,
  output logic              o_datamem_valid,
  output logic              o_misalign,
  input  logic              i_host_req_valid,
  input  logic              i_host_wr,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_din,
  output logic              o_host_req_ready,
  output logic [DATA_W-1:0] o_host_dout,
  output logic              o_host_dout_valid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(NB);

  logic [ADDR_W-1:0] cpu_idx;
  logic [OFS_W-1:0]  cpu_ofs;
  logic [2:0]        ofs3;
  logic              cpu_req, cpu_wr, cpu_rd, cpu_legal;
  logic [NB-1:0]     cpu_be;
  logic [DATA_W-1:0] cpu_wdata;
  logic              collide, host_acc, host_rd;
  logic [NB-1:0]     host_be;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              unused_hi;

  // Stage-1 pipeline (aligned with the RAM read register)
  logic              ld_v1, ld_ok1, mis1, uns1, hv1;
  logic [1:0]        size1;
  logic [2:0]        ofs1;
  logic [DATA_W-1:0] ld_data1, host_data1;

  assign cpu_idx   = i_ALU_res[OFS_W+ADDR_W-1:OFS_W];
  assign cpu_ofs   = i_ALU_res[OFS_W-1:0];
  assign ofs3      = 3'(cpu_ofs);
  assign unused_hi = ^i_ALU_res[DATA_W-1:OFS_W+ADDR_W];

  // Decode the CPU request; a simultaneous rd+wr is a store.
  always_comb begin
    cpu_req   = i_Mem_wr_en | i_Mem_rd_en;
    cpu_wr    = i_Mem_wr_en;
    cpu_rd    = i_Mem_rd_en & ~i_Mem_wr_en;
    cpu_legal = access_legal(i_mem_size, ofs3, DATA_W);
    cpu_be    = '0;
    if (cpu_wr && cpu_legal) cpu_be = NB'(be_mask(i_mem_size, ofs3, NB));
  end

  // Replicate the right-aligned store value across all lanes; the mask picks the live ones.
  always_comb begin
    int unsigned nb_sz;
    nb_sz     = 32'd1 << i_mem_size;
    cpu_wdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      cpu_wdata[i*8 +: 8] = i_ST_value[(i % nb_sz)*8 +: 8];
    end
  end

  // CPU wins any same-word conflict involving a write; ready is combinational on CPU inputs.
  always_comb begin
    collide          = cpu_req && cpu_legal && (cpu_idx == i_host_addr) && (cpu_wr || i_host_wr);
    o_host_req_ready = ~i_sys_rst & ~collide;
    host_acc         = i_host_req_valid & o_host_req_ready;
    host_rd          = host_acc & ~i_host_wr;
    host_be          = {NB{host_acc & i_host_wr}};
  end

  dp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (i_sys_clk),
    .we_a    (cpu_be),
    .addr_a  (cpu_idx),
    .wdata_a (cpu_wdata),
    .rdata_a (rdata_a),
    .we_b    (host_be),
    .addr_b  (i_host_addr),
    .wdata_b (i_host_din),
    .rdata_b (rdata_b)
  );

  // Carry request attributes alongside the RAM read; flushed by reset.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      ld_v1  <= 1'b0;
      ld_ok1 <= 1'b0;
      mis1   <= 1'b0;
      uns1   <= 1'b0;
      hv1    <= 1'b0;
      size1  <= 2'b00;
      ofs1   <= 3'b000;
    end else begin
      ld_v1  <= cpu_rd;
      ld_ok1 <= cpu_rd & cpu_legal;
      mis1   <= cpu_req & ~cpu_legal;
      uns1   <= i_mem_unsigned;
      hv1    <= host_rd;
      size1  <= i_mem_size;
      ofs1   <= ofs3;
    end
  end

  // Extract/extend the load; data is forced to zero whenever it is not a legal load result.
  always_comb begin
    ld_data1   = '0;
    host_data1 = '0;
    if (ld_ok1) ld_data1 = DATA_W'(extend(64'(rdata_a), size1, ofs1, uns1));
    if (hv1)    host_data1 = rdata_b;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      // Extra output register stage on both ports.
      always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
          o_datamem_out     <= '0;
          o_datamem_valid   <= 1'b0;
          o_misalign        <= 1'b0;
          o_host_dout       <= '0;
          o_host_dout_valid <= 1'b0;
        end else begin
          o_datamem_out     <= ld_data1;
          o_datamem_valid   <= ld_v1;
          o_misalign        <= mis1;
          o_host_dout       <= host_data1;
          o_host_dout_valid <= hv1;
        end
      end
    end else begin : g_lat1
      assign o_datamem_out     = ld_data1;
      assign o_datamem_valid   = ld_v1;
      assign o_misalign        = mis1;
      assign o_host_dout       = host_data1;
      assign o_host_dout_valid = hv1;
    end
  endgenerate

endmodule

// File: tb/tb_memory_access_dp.sv
// Directed bench: one DUT at RD_LAT=1 and one at RD_LAT=2 driven by the same inputs.
module tb_memory_access_dp;

  logic        clk, rst;
  logic        wr_en, rd_en, mem_uns;
  logic [1:0]  mem_size;
  logic [31:0] alu_res, st_value;
  logic        h_valid, h_wr;
  logic [9:0]  h_addr;
  logic [31:0] h_din;

  logic [31:0] d1_out, d2_out, d1_hdout, d2_hdout;
  logic        d1_valid, d2_valid, d1_mis, d2_mis, d1_ready, d2_ready, d1_hvalid, d2_hvalid;

  int n_tests = 0;
  int n_fail  = 0;

  memory_access_dp #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) dut1 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_Mem_wr_en(wr_en), .i_Mem_rd_en(rd_en),
    .i_mem_size(mem_size), .i_mem_unsigned(mem_uns), .i_ALU_res(alu_res), .i_ST_value(st_value),
    .o_datamem_out(d1_out), .o_datamem_valid(d1_valid), .o_misalign(d1_mis),
    .i_host_req_valid(h_valid), .i_host_wr(h_wr), .i_host_addr(h_addr), .i_host_din(h_din),
    .o_host_req_ready(d1_ready), .o_host_dout(d1_hdout), .o_host_dout_valid(d1_hvalid)
  );

  memory_access_dp #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2)) dut2 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_Mem_wr_en(wr_en), .i_Mem_rd_en(rd_en),
    .i_mem_size(mem_size), .i_mem_unsigned(mem_uns), .i_ALU_res(alu_res), .i_ST_value(st_value),
    .o_datamem_out(d2_out), .o_datamem_valid(d2_valid), .o_misalign(d2_mis),
    .i_host_req_valid(h_valid), .i_host_wr(h_wr), .i_host_addr(h_addr), .i_host_din(h_din),
    .o_host_req_ready(d2_ready), .o_host_dout(d2_hdout), .o_host_dout_valid(d2_hvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    wr_en = 1'b0; rd_en = 1'b0; mem_size = 2'b00; mem_uns = 1'b0;
    alu_res = '0; st_value = '0;
  endtask

  task automatic host_idle();
    h_valid = 1'b0; h_wr = 1'b0; h_addr = '0; h_din = '0;
  endtask

  task automatic cpu(input logic wr, input logic rd, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] st);
    wr_en = wr; rd_en = rd; mem_size = size; mem_uns = uns; alu_res = addr; st_value = st;
  endtask

  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] st);
    cpu(1'b1, 1'b0, size, 1'b0, addr, st);
    tick();
    cpu_idle();
  endtask

  // Single-cycle load on dut1; result is visible right after the next edge.
  task automatic load1(input string tag, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] exp);
    cpu(1'b0, 1'b1, size, uns, addr, '0);
    tick();
    cpu_idle();
    chk({tag, "_valid"}, 32'(d1_valid), 32'd1);
    chk({tag, "_data"}, d1_out, exp);
    chk({tag, "_mis"}, 32'(d1_mis), 32'd0);
  endtask

  logic [31:0] hexp [4];

  initial begin
    rst = 1'b1;
    cpu_idle();
    host_idle();
    tick();
    tick();
    // Reset state
    chk("rst_out", d1_out, 32'h0);
    chk("rst_valid", 32'(d1_valid), 32'd0);
    chk("rst_mis", 32'(d1_mis), 32'd0);
    chk("rst_ready", 32'(d1_ready), 32'd0);
    chk("rst_hdout", d1_hdout, 32'h0);
    chk("rst_hvalid", 32'(d2_hvalid), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(d1_ready), 32'd1);

    // 1: SW then LB signed, both latencies
    store(2'b10, 32'h10, 32'hDEADBEEF);
    cpu(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, '0);
    tick();
    cpu_idle();
    chk("lb13_l1_valid", 32'(d1_valid), 32'd1);
    chk("lb13_l1_data", d1_out, 32'hFFFFFFDE);
    chk("lb13_l2_early", 32'(d2_valid), 32'd0);
    tick();
    chk("lb13_l1_pulse", 32'(d1_valid), 32'd0);
    chk("lb13_l2_valid", 32'(d2_valid), 32'd1);
    chk("lb13_l2_data", d2_out, 32'hFFFFFFDE);
    load1("lbu13", 2'b00, 1'b1, 32'h13, 32'h000000DE);
    load1("lb10", 2'b00, 1'b0, 32'h10, 32'hFFFFFFEF);
    load1("lb11", 2'b00, 1'b0, 32'h11, 32'hFFFFFFBE);
    load1("lh12", 2'b01, 1'b0, 32'h12, 32'hFFFFDEAD);
    load1("lhu12", 2'b01, 1'b1, 32'h12, 32'h0000DEAD);

    // 2: SB into a zeroed word
    store(2'b10, 32'h20, 32'h0);
    store(2'b00, 32'h21, 32'h1234565A);
    load1("lw20", 2'b10, 1'b0, 32'h20, 32'h00005A00);
    load1("lhu22", 2'b01, 1'b1, 32'h22, 32'h00000000);

    // 3: misaligned / illegal accesses
    cpu(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, '0);
    tick();
    cpu_idle();
    chk("lh11_valid", 32'(d1_valid), 32'd1);
    chk("lh11_data", d1_out, 32'h0);
    chk("lh11_mis", 32'(d1_mis), 32'd1);
    store(2'b10, 32'h12, 32'h11111111);
    chk("sw12_novalid", 32'(d1_valid), 32'd0);
    chk("sw12_mis", 32'(d1_mis), 32'd1);
    tick();
    chk("sw12_mis_pulse", 32'(d1_mis), 32'd0);
    load1("lw10_kept", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    cpu(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, '0);
    tick();
    cpu_idle();
    chk("ld32_mis", 32'(d1_mis), 32'd1);
    chk("ld32_data", d1_out, 32'h0);

    // wr+rd together is a store with no load result
    cpu(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D);
    tick();
    cpu_idle();
    chk("wrrd_novalid", 32'(d1_valid), 32'd0);
    load1("lw30", 2'b10, 1'b0, 32'h30, 32'h0BADF00D);
    // Address bits above the word index alias
    load1("alias", 2'b10, 1'b0, 32'h1010, 32'hDEADBEEF);

    // 4: collision arbitration
    cpu(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, '0);
    h_valid = 1'b1; h_wr = 1'b0; h_addr = 10'd4;
    #1;
    chk("rd_rd_ready", 32'(d1_ready), 32'd1);
    cpu(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h55555555);
    #1;
    chk("diff_word_ready", 32'(d1_ready), 32'd1);
    tick();
    host_idle();
    cpu_idle();
    cpu(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
    h_valid = 1'b1; h_wr = 1'b1; h_addr = 10'd4; h_din = 32'h12345678;
    #1;
    chk("collide_ready", 32'(d1_ready), 32'd0);
    tick();
    cpu_idle();
    #1;
    chk("retry_ready", 32'(d1_ready), 32'd1);
    tick();
    host_idle();
    h_valid = 1'b1; h_addr = 10'd4;
    tick();
    host_idle();
    chk("hrd4_valid", 32'(d1_hvalid), 32'd1);
    chk("hrd4_data", d1_hdout, 32'h12345678);
    load1("lw10_host", 2'b10, 1'b0, 32'h10, 32'h12345678);

    // 5: RD_LAT=2 back-to-back host reads
    for (int k = 0; k < 4; k++) begin
      hexp[k] = 32'h11110000 + 32'(k);
      h_valid = 1'b1; h_wr = 1'b1; h_addr = 10'(k); h_din = hexp[k];
      tick();
    end
    host_idle();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        h_valid = 1'b1; h_wr = 1'b0; h_addr = 10'(k);
      end else begin
        host_idle();
      end
      tick();
      if (k >= 1 && k <= 4) begin
        chk($sformatf("b2b_valid%0d", k - 1), 32'(d2_hvalid), 32'd1);
        chk($sformatf("b2b_data%0d", k - 1), d2_hdout, hexp[k-1]);
      end else begin
        chk($sformatf("b2b_idle%0d", k), 32'(d2_hvalid), 32'd0);
      end
    end

    // 6: reset with a load in flight on the RD_LAT=2 instance
    cpu(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, '0);
    tick();
    cpu_idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_d1_valid", 32'(d1_valid), 32'd0);
    chk("rst_d1_out", d1_out, 32'h0);
    tick();
    chk("rst_d2_valid", 32'(d2_valid), 32'd0);
    chk("rst_d2_out", d2_out, 32'h0);
    chk("rst_mid_ready", 32'(d2_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(d2_valid), 32'd0);
    cpu(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, '0);
    tick();
    cpu_idle();
    tick();
    chk("post_rst_valid", 32'(d2_valid), 32'd1);
    chk("post_rst_data", d2_out, 32'h11110001);
    load1("post_rst_lw10", 2'b10, 1'b0, 32'h10, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
